// File: rtl/cache_line_axi_ctrl.sv
// Cache-side sequencer for an AXI full-burst master: runs an optional victim
// writeback burst, then the refill burst, and returns the packed line with an error flag.
module cache_line_axi_ctrl #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int LINE_WORDS = 8
) (
  input  logic                             M_AXI_ACLK,
  input  logic                             M_AXI_ARESETN,
  input  logic                             req_valid,
  output logic                             req_ready,
  input  logic [ADDR_WIDTH-1:0]            req_refill_addr,
  input  logic                             req_wb,
  input  logic [ADDR_WIDTH-1:0]            req_wb_addr,
  input  logic [LINE_WORDS*DATA_WIDTH-1:0] req_wb_line,
  output logic                             resp_valid,
  output logic [LINE_WORDS*DATA_WIDTH-1:0] resp_line,
  output logic                             resp_err,
  output logic                             user_start,
  output logic                             user_rw,
  output logic [ADDR_WIDTH-1:0]            user_addr,
  output logic [7:0]                       user_len,
  output logic [DATA_WIDTH-1:0]            user_wdata,
  output logic                             user_wvalid,
  input  logic                             user_wready,
  input  logic [DATA_WIDTH-1:0]            user_rdata,
  input  logic                             user_rvalid,
  output logic                             user_rready,
  input  logic                             user_busy,
  input  logic                             user_done,
  input  logic                             user_error
);

  localparam int OFF = $clog2(LINE_WORDS * DATA_WIDTH / 8);
  localparam int CW  = $clog2(LINE_WORDS + 1);
  localparam int IW  = $clog2(LINE_WORDS);
  localparam logic [CW-1:0]         LW_C  = CW'(LINE_WORDS);
  localparam logic [ADDR_WIDTH-1:0] ALIGN = {ADDR_WIDTH{1'b1}} << OFF;

  typedef enum logic [2:0] {
    IDLE, WB_START, WB_DATA, RF_START, RF_DATA, RESP
  } state_t;

  state_t                               state, state_nxt;
  logic [ADDR_WIDTH-1:0]                wb_addr_q, rf_addr_q;
  logic [LINE_WORDS-1:0][DATA_WIDTH-1:0] wb_buf, rf_buf;
  logic [CW-1:0]                        wcnt, rcnt;
  logic                                 err_q;
  logic                                 w_fire, r_take, short_burst;
  logic [IW-1:0]                        widx, ridx;

  assign widx        = wcnt[IW-1:0];
  assign ridx        = rcnt[IW-1:0];
  assign w_fire      = user_wvalid && user_wready;
  assign r_take      = (state == RF_DATA) && user_rvalid && (rcnt < LW_C);
  // A beat arriving together with user_done still counts toward a full line.
  assign short_burst = (rcnt + CW'(r_take)) < LW_C;

  assign resp_line = rf_buf;
  assign user_len  = 8'(LINE_WORDS);

  // NOTE: state and datapath registers use non-blocking assignments so every
  // flop samples the pre-edge values, independent of process ordering.
  always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
    if (!M_AXI_ARESETN) state <= IDLE;
    else                state <= state_nxt;
  end

  // NOTE: every output and next-state term gets a default before the case, so
  // no path through the block leaves a value unassigned and no latch is inferred.
  always_comb begin
    state_nxt   = state;
    req_ready   = 1'b0;
    resp_valid  = 1'b0;
    resp_err    = 1'b0;
    user_start  = 1'b0;
    user_rw     = 1'b0;
    user_addr   = '0;
    user_wvalid = 1'b0;
    user_wdata  = '0;
    user_rready = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_nxt = req_wb ? WB_START : RF_START;
      end
      WB_START: begin
        if (!user_busy) begin
          user_start = 1'b1;
          user_addr  = wb_addr_q;
          state_nxt  = WB_DATA;
        end
      end
      WB_DATA: begin
        if (wcnt < LW_C) begin
          user_wvalid = 1'b1;
          user_wdata  = wb_buf[widx];
        end
        if (user_done) state_nxt = RF_START;
      end
      RF_START: begin
        if (!user_busy) begin
          user_start = 1'b1;
          user_rw    = 1'b1;
          user_addr  = rf_addr_q;
          state_nxt  = RF_DATA;
        end
      end
      RF_DATA: begin
        user_rready = 1'b1;
        if (user_done) state_nxt = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        resp_err   = err_q;
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: the line buffers are reset because resp_line exposes them directly
  // and stale words of a short refill must be deterministic after reset.
  always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
    if (!M_AXI_ARESETN) begin
      wb_addr_q <= '0;
      rf_addr_q <= '0;
      wb_buf    <= '0;
      rf_buf    <= '0;
      wcnt      <= '0;
      rcnt      <= '0;
      err_q     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            wb_addr_q <= req_wb_addr & ALIGN;
            rf_addr_q <= req_refill_addr & ALIGN;
            wb_buf    <= req_wb_line;
            wcnt      <= '0;
            rcnt      <= '0;
            err_q     <= 1'b0;
          end
        end
        WB_DATA: begin
          if (w_fire)    wcnt  <= wcnt + CW'(1);
          if (user_done) err_q <= err_q | user_error;
        end
        RF_DATA: begin
          if (r_take) begin
            rf_buf[ridx] <= user_rdata;
            rcnt         <= rcnt + CW'(1);
          end
          if (user_done) err_q <= err_q | user_error | short_burst;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cache_line_axi_ctrl.sv
// Bench for cache_line_axi_ctrl: a behavioural burst master plus a line-level
// reference model, driven by a vector table, random transactions and corner sequences.
module tb_cache_line_axi_ctrl;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int LW = 8;
  localparam int LB = LW * DW;
  localparam logic [AW-1:0] MASK = 32'hFFFF_FFE0;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_valid = 1'b0, req_ready, req_wb = 1'b0;
  logic [AW-1:0] req_refill_addr = '0, req_wb_addr = '0;
  logic [LB-1:0] req_wb_line = '0, resp_line;
  logic          resp_valid, resp_err;
  logic          user_start, user_rw, user_wvalid, user_rready;
  logic [AW-1:0] user_addr;
  logic [7:0]    user_len;
  logic [DW-1:0] user_wdata, user_rdata = '0;
  logic          user_wready = 1'b0, user_rvalid = 1'b0, user_busy = 1'b0;
  logic          user_done = 1'b0, user_error = 1'b0;

  always #5 clk = ~clk;

  cache_line_axi_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LINE_WORDS(LW)) dut (
    .M_AXI_ACLK(clk), .M_AXI_ARESETN(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_refill_addr(req_refill_addr),
    .req_wb(req_wb), .req_wb_addr(req_wb_addr), .req_wb_line(req_wb_line),
    .resp_valid(resp_valid), .resp_line(resp_line), .resp_err(resp_err),
    .user_start(user_start), .user_rw(user_rw), .user_addr(user_addr), .user_len(user_len),
    .user_wdata(user_wdata), .user_wvalid(user_wvalid), .user_wready(user_wready),
    .user_rdata(user_rdata), .user_rvalid(user_rvalid), .user_rready(user_rready),
    .user_busy(user_busy), .user_done(user_done), .user_error(user_error)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [LB-1:0] got, input logic [LB-1:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  task automatic timeout_fail(input string name);
    n_checks++;
    $display("FAIL %s: timed out", name);
  endtask

  // Master behaviour knobs, set per transaction.
  int            cfg_rd_beats = LW, cfg_tail = 0, cfg_wready_pct = 100, cfg_rvalid_pct = 100;
  bit            cfg_wr_err = 0, cfg_rd_err = 0, cfg_done_last = 0;
  logic [DW-1:0] rd_seed = '0;

  typedef struct packed {
    logic          rw;
    logic [AW-1:0] addr;
    logic [7:0]    len;
  } burst_t;

  burst_t        start_q[$];
  logic [DW-1:0] wdata_q[$];
  logic [LB-1:0] resp_line_q[$];
  logic          resp_err_q[$];
  int            resp_cyc_q[$];
  int            acc_cyc_q[$];
  int            rbeats = 0, busy_viol = 0, cyc = 0;

  int m_cnt = 0, m_tail = 0;
  bit m_active = 0, m_rw = 0;

  // Monitor samples at negedge; the master model reacts just after posedge.
  always begin : master
    bit st, st_rw, wf, rf, df;
    @(negedge clk);
    cyc++;
    st = 0; st_rw = 0; wf = 0; rf = 0; df = 0;
    if (rst_n) begin
      st    = user_start;
      st_rw = user_rw;
      wf    = user_wvalid && user_wready;
      rf    = user_rvalid && user_rready;
      df    = user_done;
      if (st) begin
        start_q.push_back('{user_rw, user_addr, user_len});
        if (user_busy) busy_viol++;
      end
      if (wf) wdata_q.push_back(user_wdata);
      if (rf) rbeats++;
      if (resp_valid) begin
        resp_line_q.push_back(resp_line);
        resp_err_q.push_back(resp_err);
        resp_cyc_q.push_back(cyc);
      end
      if (req_valid && req_ready) acc_cyc_q.push_back(cyc);
    end
    @(posedge clk);
    #1;
    if (!rst_n) begin
      user_busy = 0; user_done = 0; user_error = 0; user_wready = 0;
      user_rvalid = 0; user_rdata = '0;
      m_active = 0; m_tail = 0; m_cnt = 0;
    end else begin
      if (!m_active && m_tail > 0) begin
        m_tail--;
        if (m_tail == 0) user_busy = 0;
      end
      if (df) begin
        user_done = 0; user_error = 0; user_rvalid = 0; user_wready = 0;
        m_active = 0;
        if (m_rw) rd_seed = rd_seed + 32'h100;
        if (cfg_tail == 0) user_busy = 0;
        else m_tail = cfg_tail;
      end
      if (st) begin
        m_active = 1; m_rw = st_rw; m_cnt = 0; m_tail = 0; user_busy = 1;
      end
      if (m_active && !m_rw) begin
        if (wf) m_cnt++;
        if (m_cnt >= LW) begin
          user_wready = 0; user_done = 1; user_error = cfg_wr_err;
        end else begin
          user_wready = ($urandom_range(99) < cfg_wready_pct);
        end
      end else if (m_active) begin
        if (rf) m_cnt++;
        if (m_cnt >= cfg_rd_beats) begin
          user_rvalid = 0; user_done = 1; user_error = cfg_rd_err;
        end else if (cfg_done_last && m_cnt == cfg_rd_beats - 1) begin
          user_rvalid = 1; user_rdata = rd_seed + DW'(m_cnt);
          user_done = 1; user_error = cfg_rd_err;
        end else if ($urandom_range(99) < cfg_rvalid_pct) begin
          user_rvalid = 1; user_rdata = rd_seed + DW'(m_cnt);
        end else begin
          user_rvalid = 0; user_rdata = $urandom;
        end
      end
    end
  end

  function automatic logic [LB-1:0] line_of(input logic [DW-1:0] base);
    logic [LB-1:0] l;
    for (int i = 0; i < LW; i++) l[i*DW +: DW] = base + DW'(i);
    return l;
  endfunction

  // Refill result: the first min(beats, LW) words are new, the rest keep the previous line.
  function automatic logic [LB-1:0] model_line(input logic [LB-1:0] prev,
                                               input logic [DW-1:0] seed, input int beats);
    logic [LB-1:0] l;
    l = prev;
    for (int i = 0; i < LW; i++) if (i < beats) l[i*DW +: DW] = seed + DW'(i);
    return l;
  endfunction

  function automatic int count_of(input int which);
    case (which)
      0:       return acc_cyc_q.size();
      1:       return resp_cyc_q.size();
      default: return rbeats;
    endcase
  endfunction

  task automatic wait_for(input int which, input int target, input int budget, input string name);
    int n;
    n = 0;
    while (count_of(which) < target && n < budget) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (count_of(which) < target) timeout_fail(name);
  endtask

  task automatic clear_logs();
    start_q.delete(); wdata_q.delete(); resp_line_q.delete(); resp_err_q.delete();
    resp_cyc_q.delete(); acc_cyc_q.delete(); rbeats = 0; busy_viol = 0;
  endtask

  typedef struct {
    logic [AW-1:0] raddr;
    logic          wb;
    logic [AW-1:0] waddr;
    logic [DW-1:0] wbase;
    logic [DW-1:0] rseed;
    int            beats;
    bit            wr_err, rd_err, done_last;
    int            tail, wpct, rpct;
    logic          exp_err;
    int            exp_starts;
  } vec_t;

  logic [LB-1:0] prev_line = '0;

  task automatic set_cfg(input vec_t v);
    cfg_rd_beats = v.beats; cfg_wr_err = v.wr_err; cfg_rd_err = v.rd_err;
    cfg_done_last = v.done_last; cfg_tail = v.tail;
    cfg_wready_pct = v.wpct; cfg_rvalid_pct = v.rpct; rd_seed = v.rseed;
  endtask

  task automatic run_txn(input vec_t v, input string tag);
    logic [LB-1:0] exp_line;
    burst_t        exp_b[$];
    @(posedge clk);
    #1;
    clear_logs();
    set_cfg(v);
    req_valid = 1; req_refill_addr = v.raddr; req_wb = v.wb;
    req_wb_addr = v.waddr; req_wb_line = line_of(v.wbase);
    wait_for(0, 1, 20, {tag, " accept"});
    @(posedge clk);
    #1;
    req_valid = 0;
    wait_for(1, 1, 3000, {tag, " resp"});
    repeat (4) @(negedge clk);
    #1;
    exp_line = model_line(prev_line, v.rseed, v.beats);
    check({tag, " resp_count"}, LB'(resp_cyc_q.size()), LB'(1));
    if (resp_line_q.size() > 0) begin
      check({tag, " resp_line"}, resp_line_q[0], exp_line);
      check({tag, " resp_err"}, LB'(resp_err_q[0]), LB'(v.exp_err));
    end
    if (v.wb) exp_b.push_back('{1'b0, v.waddr & MASK, 8'(LW)});
    exp_b.push_back('{1'b1, v.raddr & MASK, 8'(LW)});
    check({tag, " start_count"}, LB'(start_q.size()), LB'(v.exp_starts));
    for (int i = 0; i < exp_b.size() && i < start_q.size(); i++)
      check($sformatf("%s burst%0d", tag, i), LB'(start_q[i]), LB'(exp_b[i]));
    check({tag, " wbeats"}, LB'(wdata_q.size()), LB'(v.wb ? LW : 0));
    for (int i = 0; i < wdata_q.size() && i < LW; i++)
      check($sformatf("%s wdata%0d", tag, i), LB'(wdata_q[i]), LB'(v.wbase + DW'(i)));
    check({tag, " start_while_busy"}, LB'(busy_viol), LB'(0));
    prev_line = exp_line;
  endtask

  vec_t vecs[8];

  initial begin
    vecs[0] = '{raddr:32'h1000_0014, wb:0, waddr:0, wbase:0, rseed:32'hA0, beats:8,
                wr_err:0, rd_err:0, done_last:0, tail:0, wpct:100, rpct:100, exp_err:0, exp_starts:1};
    vecs[1] = '{raddr:32'h3000_0044, wb:1, waddr:32'h2000_0020, wbase:32'h100, rseed:32'hB0, beats:8,
                wr_err:0, rd_err:0, done_last:0, tail:3, wpct:100, rpct:100, exp_err:0, exp_starts:2};
    vecs[2] = '{raddr:32'h0000_1234, wb:1, waddr:32'h0000_5678, wbase:32'h200, rseed:32'hC0, beats:8,
                wr_err:0, rd_err:0, done_last:0, tail:1, wpct:40, rpct:50, exp_err:0, exp_starts:2};
    vecs[3] = '{raddr:32'h4000_0000, wb:1, waddr:32'h4100_001C, wbase:32'h300, rseed:32'hD0, beats:8,
                wr_err:1, rd_err:0, done_last:0, tail:0, wpct:70, rpct:100, exp_err:1, exp_starts:2};
    vecs[4] = '{raddr:32'h4200_0060, wb:0, waddr:0, wbase:0, rseed:32'hE0, beats:8,
                wr_err:0, rd_err:1, done_last:0, tail:0, wpct:100, rpct:100, exp_err:1, exp_starts:1};
    vecs[5] = '{raddr:32'h4300_0080, wb:0, waddr:0, wbase:0, rseed:32'hF0, beats:5,
                wr_err:0, rd_err:0, done_last:0, tail:0, wpct:100, rpct:60, exp_err:1, exp_starts:1};
    vecs[6] = '{raddr:32'h4400_00A0, wb:0, waddr:0, wbase:0, rseed:32'h1F0, beats:10,
                wr_err:0, rd_err:0, done_last:0, tail:0, wpct:100, rpct:100, exp_err:0, exp_starts:1};
    vecs[7] = '{raddr:32'h4500_00C0, wb:1, waddr:32'h4600_00E0, wbase:32'h400, rseed:32'h2F0, beats:8,
                wr_err:0, rd_err:0, done_last:1, tail:0, wpct:100, rpct:70, exp_err:0, exp_starts:2};

    // Reset state.
    repeat (3) @(negedge clk);
    check("rst req_ready", LB'(req_ready), LB'(1));
    check("rst resp_valid", LB'(resp_valid), LB'(0));
    check("rst user_start", LB'(user_start), LB'(0));
    check("rst user_len", LB'(user_len), LB'(LW));
    check("rst user_wvalid", LB'(user_wvalid), LB'(0));
    check("rst user_rready", LB'(user_rready), LB'(0));
    check("rst user_addr", LB'(user_addr), LB'(0));
    check("rst resp_line", resp_line, '0);
    rst_n = 1;

    for (int i = 0; i < 8; i++) run_txn(vecs[i], $sformatf("vec%0d", i));

    for (int i = 0; i < 20; i++) begin
      vec_t v;
      v.raddr = $urandom; v.wb = 1'($urandom_range(1, 0)); v.waddr = $urandom;
      v.wbase = $urandom; v.rseed = $urandom; v.beats = $urandom_range(10, 3);
      v.wr_err = ($urandom_range(3, 0) == 0); v.rd_err = ($urandom_range(3, 0) == 0);
      v.done_last = 1'($urandom_range(1, 0)); v.tail = $urandom_range(3, 0);
      v.wpct = $urandom_range(100, 30); v.rpct = $urandom_range(100, 30);
      v.exp_err = (v.wb && v.wr_err) || v.rd_err || (v.beats < LW);
      v.exp_starts = v.wb ? 2 : 1;
      run_txn(v, $sformatf("rand%0d", i));
    end

    // Back-to-back: req_valid held; second request accepted the cycle after resp_valid.
    begin
      vec_t v;
      logic [LB-1:0] line_a;
      v = vecs[0];
      v.rseed = 32'h500;
      @(posedge clk);
      #1;
      clear_logs();
      set_cfg(v);
      req_valid = 1; req_wb = 0; req_refill_addr = 32'h4000_0000;
      wait_for(0, 1, 20, "b2b accept A");
      @(posedge clk);
      #1;
      req_wb = 1; req_wb_addr = 32'h5000_0000; req_wb_line = line_of(32'h900);
      req_refill_addr = 32'h6000_0000;
      wait_for(0, 2, 200, "b2b accept B");
      @(posedge clk);
      #1;
      req_valid = 0;
      wait_for(1, 2, 400, "b2b resp B");
      line_a = model_line(prev_line, 32'h500, LW);
      check("b2b resp_count", LB'(resp_cyc_q.size()), LB'(2));
      if (resp_cyc_q.size() >= 2 && acc_cyc_q.size() >= 2) begin
        check("b2b accept timing", LB'(acc_cyc_q[1]), LB'(resp_cyc_q[0] + 1));
        check("b2b line A", resp_line_q[0], line_a);
        check("b2b line B", resp_line_q[1], model_line(line_a, 32'h600, LW));
        check("b2b err B", LB'(resp_err_q[1]), LB'(0));
      end
      check("b2b wbeats", LB'(wdata_q.size()), LB'(LW));
      if (wdata_q.size() > 0) check("b2b wdata0", LB'(wdata_q[0]), LB'(32'h900));
      prev_line = model_line(line_a, 32'h600, LW);
    end

    // Async reset in the middle of the refill burst.
    begin
      vec_t v;
      v = vecs[0];
      v.rseed = 32'h700;
      @(posedge clk);
      #1;
      clear_logs();
      set_cfg(v);
      req_valid = 1; req_wb = 0; req_refill_addr = 32'h7000_0000;
      wait_for(0, 1, 20, "rst accept");
      @(posedge clk);
      #1;
      req_valid = 0;
      wait_for(2, 3, 100, "rst beats");
      @(posedge clk);
      #3;
      rst_n = 0;
      #1;
      check("midrst req_ready", LB'(req_ready), LB'(1));
      check("midrst user_rready", LB'(user_rready), LB'(0));
      check("midrst resp_valid", LB'(resp_valid), LB'(0));
      check("midrst resp_line", resp_line, '0);
      check("midrst user_start", LB'(user_start), LB'(0));
      repeat (2) @(negedge clk);
      rst_n = 1;
      repeat (10) @(negedge clk);
      #1;
      check("postrst req_ready", LB'(req_ready), LB'(1));
      check("postrst no resp", LB'(resp_cyc_q.size()), LB'(0));
      prev_line = '0;
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
